// File: rtl/fft_pkg.sv
// Shared definitions for the MDC FFT butterfly datapath: the default sample
// width and the butterfly mode encoding carried alongside every sample pair.
package fft_pkg;

  localparam int DEFAULT_DW = 9;

  typedef enum logic [1:0] {
    MODE_COMPUTE = 2'b00,
    MODE_BYPASS  = 2'b01,
    MODE_SCALED  = 2'b10,
    MODE_SWAP    = 2'b11
  } mode_e;

endpackage

// File: rtl/bfly_core.sv
// Combinational radix-2 butterfly for one complex pair. Sums are formed two bits
// wider than the input so the scaled round-half-up can never wrap.
module bfly_core
  import fft_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  mode_e                mode_i,
  input  logic signed [DW-1:0] x0Re_i,
  input  logic signed [DW-1:0] x0Im_i,
  input  logic signed [DW-1:0] x1Re_i,
  input  logic signed [DW-1:0] x1Im_i,
  output logic signed [DW:0]   y0Re_o,
  output logic signed [DW:0]   y0Im_o,
  output logic signed [DW:0]   y1Re_o,
  output logic signed [DW:0]   y1Im_o
);

  localparam int SW = DW + 2;

  logic signed [SW-1:0] sumRe, sumIm, difRe, difIm;

  function automatic logic signed [DW:0] roundHalf(input logic signed [SW-1:0] s);
    return (DW+1)'((s + SW'(1)) >>> 1);
  endfunction

  always_comb begin
    sumRe = SW'(x0Re_i) + SW'(x1Re_i);
    sumIm = SW'(x0Im_i) + SW'(x1Im_i);
    difRe = SW'(x0Re_i) - SW'(x1Re_i);
    difIm = SW'(x0Im_i) - SW'(x1Im_i);
  end

  always_comb begin
    y0Re_o = '0;
    y0Im_o = '0;
    y1Re_o = '0;
    y1Im_o = '0;
    case (mode_i)
      MODE_COMPUTE: begin
        y0Re_o = (DW+1)'(sumRe);
        y0Im_o = (DW+1)'(sumIm);
        y1Re_o = (DW+1)'(difRe);
        y1Im_o = (DW+1)'(difIm);
      end
      MODE_BYPASS: begin
        y0Re_o = (DW+1)'(x0Re_i);
        y0Im_o = (DW+1)'(x0Im_i);
        y1Re_o = (DW+1)'(x1Re_i);
        y1Im_o = (DW+1)'(x1Im_i);
      end
      MODE_SCALED: begin
        y0Re_o = roundHalf(sumRe);
        y0Im_o = roundHalf(sumIm);
        y1Re_o = roundHalf(difRe);
        y1Im_o = roundHalf(difIm);
      end
      MODE_SWAP: begin
        y0Re_o = (DW+1)'(x1Re_i);
        y0Im_o = (DW+1)'(x1Im_i);
        y1Re_o = (DW+1)'(x0Re_i);
        y1Im_o = (DW+1)'(x0Im_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/butterfly_pipe.sv
// Elastic, pipelined radix-2 butterfly for one MDC stage: 1 or 2 register
// stages with valid/ready flow control and a tag riding along with each pair.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter  int DW    = DEFAULT_DW,
  parameter  int PIPE  = 2,
  parameter  int TAG_W = 5,
  localparam int OW    = DW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic signed [DW-1:0] x0_re,
  input  logic signed [DW-1:0] x0_im,
  input  logic signed [DW-1:0] x1_re,
  input  logic signed [DW-1:0] x1_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic signed [OW-1:0] y0_re,
  output logic signed [OW-1:0] y0_im,
  output logic signed [OW-1:0] y1_re,
  output logic signed [OW-1:0] y1_im,
  output logic                 busy
);

  mode_e                coreMode;
  logic signed [DW-1:0] coreX0Re, coreX0Im, coreX1Re, coreX1Im;
  logic signed [OW-1:0] coreY0Re, coreY0Im, coreY1Re, coreY1Im;
  logic                 stageValid;
  logic [TAG_W-1:0]     stageTag;

  logic                 outValid_q;
  logic [TAG_W-1:0]     outTag_q;
  logic signed [OW-1:0] y0Re_q, y0Im_q, y1Re_q, y1Im_q;
  logic                 outLoad;

  // The last stage may take new data when empty or when its pair leaves now.
  assign outLoad = !outValid_q || out_ready;

  bfly_core #(.DW(DW)) uCore (
    .mode_i (coreMode),
    .x0Re_i (coreX0Re),
    .x0Im_i (coreX0Im),
    .x1Re_i (coreX1Re),
    .x1Im_i (coreX1Im),
    .y0Re_o (coreY0Re),
    .y0Im_o (coreY0Im),
    .y1Re_o (coreY1Re),
    .y1Im_o (coreY1Im)
  );

  if (PIPE != 1 && PIPE != 2) begin : gBadPipe
    $error("butterfly_pipe: PIPE must be 1 or 2");
  end

  if (PIPE == 2) begin : gTwoStage
    logic                 inValid_q;
    mode_e                mode_q;
    logic [TAG_W-1:0]     tag_q;
    logic signed [DW-1:0] x0Re_q, x0Im_q, x1Re_q, x1Im_q;
    logic                 inLoad;

    assign inLoad   = !inValid_q || outLoad;
    assign in_ready = rst_n && inLoad;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        inValid_q <= 1'b0;
        mode_q    <= MODE_COMPUTE;
        tag_q     <= '0;
        x0Re_q    <= '0;
        x0Im_q    <= '0;
        x1Re_q    <= '0;
        x1Im_q    <= '0;
      end else if (inLoad) begin
        inValid_q <= in_valid;
        if (in_valid) begin
          mode_q <= mode_e'(in_mode);
          tag_q  <= in_tag;
          x0Re_q <= x0_re;
          x0Im_q <= x0_im;
          x1Re_q <= x1_re;
          x1Im_q <= x1_im;
        end
      end
    end

    assign coreMode   = mode_q;
    assign coreX0Re   = x0Re_q;
    assign coreX0Im   = x0Im_q;
    assign coreX1Re   = x1Re_q;
    assign coreX1Im   = x1Im_q;
    assign stageValid = inValid_q;
    assign stageTag   = tag_q;
    assign busy       = inValid_q || outValid_q;
  end else begin : gOneStage
    assign in_ready   = rst_n && outLoad;
    assign coreMode   = mode_e'(in_mode);
    assign coreX0Re   = x0_re;
    assign coreX0Im   = x0_im;
    assign coreX1Re   = x1_re;
    assign coreX1Im   = x1_im;
    assign stageValid = in_valid;
    assign stageTag   = in_tag;
    assign busy       = outValid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outTag_q   <= '0;
      y0Re_q     <= '0;
      y0Im_q     <= '0;
      y1Re_q     <= '0;
      y1Im_q     <= '0;
    end else if (outLoad) begin
      outValid_q <= stageValid;
      if (stageValid) begin
        outTag_q <= stageTag;
        y0Re_q   <= coreY0Re;
        y0Im_q   <= coreY0Im;
        y1Re_q   <= coreY1Re;
        y1Im_q   <= coreY1Im;
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_tag   = outTag_q;
  assign y0_re     = y0Re_q;
  assign y0_im     = y0Im_q;
  assign y1_re     = y1Re_q;
  assign y1_im     = y1Im_q;

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
Parametrised, pipelined radix-2 butterfly for the MDC FFT datapath. It is the successor to the combinational compute/bypass butterfly. It adds registered stages, valid/ready flow control, a scaled-compute mode with rounding, a swap mode for commutator use, and a sideband tag that travels with each sample pair. One instance sits in each MDC stage, between the delay-commutator and the twiddle multiplier.

Parameters:
DW, 9, input component width (signed two's complement); output width OW = DW+1 (localparam)
PIPE, 2, pipeline depth, 1 or 2; any other value is a compile-time error
TAG_W, 5, sideband tag width (sample index), passed through unmodified

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  input pair valid
in_ready  out  1  block accepts input this cycle
in_mode  in  2  00 compute, 01 bypass, 10 compute scaled, 11 swap bypass
in_tag  in  TAG_W  sideband tag
x0_re, x0_im, x1_re, x1_im  in  DW each  signed input pair
out_valid  out  1  output pair valid
out_ready  in  1  downstream accepts output
out_tag  out  TAG_W  tag of the output pair
y0_re, y0_im, y1_re, y1_im  out  OW each  signed output pair
busy  out  1  high when any stage holds valid data

Behaviour:
- Reset: synchronous. Sampled low at a rising edge, it clears all stage valid bits and zeroes all data, tag and mode registers. After that edge: out_valid=0, outputs=0, out_tag=0, busy=0. in_ready=0 while rst_n=0, and it is high on the first cycle after reset is released.
- Reset mid-operation flushes every in-flight pair. Those pairs never appear at the output.
- Transfer: input handshake when in_valid and in_ready are both high. Output handshake when out_valid and out_ready are both high.
- Elastic pipeline:
  - Stage k loads when it is empty or when its contents move forward in the same cycle.
  - in_ready = !v[0] or (stage 0 advances this cycle).
  - The last stage advances on out_ready.
  - There are no bubbles under continuous valid/ready: one pair per cycle.
- Latency: a pair accepted at edge N is presented with out_valid=1 after edge N+PIPE-1, i.e. on the cycle following the PIPE-th edge counted from acceptance.
- PIPE=2:
  - Stage 0 registers inputs, mode and tag.
  - Stage 1 registers the arithmetic results.
- PIPE=1: the arithmetic is computed from the inputs and registered in one stage.
- Arithmetic: inputs are sign-extended to OW before any add or subtract, so no overflow is possible.
  - 00 compute: y0 = x0+x1, y1 = x0−x1 (re and im independently).
  - 01 bypass: y0 = sext(x0), y1 = sext(x1).
  - 10 scaled: s = x0±x1 at OW bits, y = (s+1)>>>1, i.e. round-half-up; the result is in range and is sign-extended to OW.
  - 11 swap: y0 = sext(x1), y1 = sext(x0).
- Mode and tag are sampled together with the data and stay attached to that pair through every stage.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable. Once every stage is full, in_ready drops. No pair is dropped or duplicated.
- Simultaneous accept and emit with the pipeline full: throughput is sustained and in_ready stays high.
- busy = OR of all stage valid bits.
- out_valid does not combinationally depend on in_valid. in_ready may combinationally depend on out_ready.

Decomposition:
- fft_pkg holds:
  - mode encodings MODE_COMPUTE=2'b00, MODE_BYPASS=2'b01, MODE_SCALED=2'b10, MODE_SWAP=2'b11
  - the default DW
- A natural sub-module is bfly_core: a combinational OW-wide add/sub/scale/swap for one complex pair, instantiated once. The register stages and handshake logic stay in butterfly_pipe.

Test Plan:
- DW=9, PIPE=2, compute: x0=(100,−50), x1=(27,20) -> y0=(127,−30), y1=(73,−70), tag preserved, out_valid two cycles after acceptance.
- Extremes, compute: x0=x1=(255,−256) -> y0=(510,−512), y1=(0,0). Swap with x0=(1,2), x1=(3,4) -> y0=(3,4), y1=(1,2).
- Scaled rounding: x0=(3,−3), x1=(0,0) -> y0=(2,−1), y1=(2,−1). x0=x1=(255,−256) -> y0=(255,−256).
- Backpressure: stream tags 0..15 with out_ready low for 3 cycles mid-stream -> in_ready falls once 2 pairs are held, outputs stay stable, all 16 tags emerge in order exactly once, and throughput returns to 1/cycle.
- Reset mid-stream: rst_n low for 1 edge with the pipeline full -> next cycle out_valid=0, busy=0, outputs 0. The first post-reset input appears PIPE cycles later and no stale pair is emitted.
- PIPE=1 variant: the same vectors give identical results with latency 1. Random mode/data/ready over 10k pairs matches the reference model.
